// File: rtl/regex_pc_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regex_pc_scheduler: two-bank PC thread scheduler in front of the regex    |
// | CPU; dispatches current-character PCs and advances the character stream. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module regex_pc_scheduler #(
  parameter int PC_WIDTH        = 8,
  parameter int CHARACTER_WIDTH = 8,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       char_in_valid,
  input  logic [CHARACTER_WIDTH-1:0] char_in_data,
  output logic                       char_in_ready,
  output logic [CHARACTER_WIDTH-1:0] current_character,
  output logic                       cpu_pc_valid,
  output logic [PC_WIDTH-1:0]        cpu_pc,
  input  logic                       cpu_pc_ready,
  input  logic                       ret_pc_valid,
  input  logic [PC_WIDTH-1:0]        ret_pc,
  input  logic                       ret_pc_is_directed_to_current,
  output logic                       ret_pc_ready,
  input  logic                       cpu_running,
  input  logic                       cpu_accepts,
  output logic                       busy,
  output logic                       done,
  output logic                       accepted,
  output logic [COUNT_WIDTH-1:0]     char_count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       sel;
  logic [1:0] quiet_count;

  logic [PC_WIDTH-1:0]        mem [2][DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr [2];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr [2];
  logic [CW-1:0]              count [2];

  logic start_ok;
  logic cur_empty;
  logic nxt_empty;
  logic tgt;
  logic pop;
  logic push;
  logic quiescent;
  logic quiet_done;
  logic bank_pop [2];
  logic bank_push [2];

  assign start_ok   = start && (state == S_IDLE || state == S_DONE);
  assign cur_empty  = (count[sel] == '0);
  assign nxt_empty  = (count[~sel] == '0);
  assign tgt        = ret_pc_is_directed_to_current ? sel : ~sel;
  assign pop        = cpu_pc_valid && cpu_pc_ready;
  assign push       = ret_pc_valid && ret_pc_ready;
  assign quiescent  = cur_empty && !cpu_running && !ret_pc_valid && !pop;
  // Second consecutive quiescent cycle: nothing can still be in flight.
  assign quiet_done = (state == S_RUN) && quiescent && (quiet_count != 2'd0);

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_pop[b]  = pop && (sel == 1'(b));
      bank_push[b] = push && (tgt == 1'(b));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_LOAD;
      S_LOAD:         if (char_in_valid) state_next = S_RUN;
      S_RUN: begin
        if (cpu_accepts) begin
          state_next = S_DONE;
        end else if (quiet_done) begin
          if (current_character == '0 || nxt_empty) state_next = S_DONE;
          else                                       state_next = S_LOAD;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state == S_LOAD) || (state == S_RUN);
    done          = (state == S_DONE);
    char_in_ready = (state == S_LOAD);
    cpu_pc_valid  = (state == S_RUN) && !cur_empty;
    cpu_pc        = mem[sel][rd_ptr[sel]];
    // A full CUR still accepts when its head leaves in the same cycle.
    ret_pc_ready  = (state == S_RUN) &&
                    ((count[tgt] != FULL_COUNT) ||
                     ((tgt == sel) && cpu_pc_valid && cpu_pc_ready));
  end

  always_ff @(posedge clk) begin
    if (start_ok)  mem[0][0] <= '0;
    else if (push) mem[tgt][wr_ptr[tgt]] <= ret_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel               <= 1'b0;
      quiet_count       <= 2'd0;
      current_character <= '0;
      char_count        <= '0;
      accepted          <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        rd_ptr[b] <= '0;
        wr_ptr[b] <= '0;
        count[b]  <= '0;
      end
    end else begin
      if (start_ok) begin
        sel        <= 1'b0;
        char_count <= '0;
        accepted   <= 1'b0;
        rd_ptr[0]  <= '0;
        wr_ptr[0]  <= FIFO_DEPTH_LOG2'(1);
        count[0]   <= CW'(1);
        rd_ptr[1]  <= '0;
        wr_ptr[1]  <= '0;
        count[1]   <= '0;
      end
      if (state == S_LOAD && char_in_valid) begin
        current_character <= char_in_data;
        quiet_count       <= 2'd0;
        if (char_count != {COUNT_WIDTH{1'b1}})
          char_count <= char_count + COUNT_WIDTH'(1);
      end
      if (state == S_RUN) begin
        if (quiescent)
          quiet_count <= (quiet_count == 2'd3) ? quiet_count : quiet_count + 2'd1;
        else
          quiet_count <= 2'd0;
        for (int b = 0; b < 2; b++) begin
          rd_ptr[b] <= rd_ptr[b] + FIFO_DEPTH_LOG2'(bank_pop[b]);
          wr_ptr[b] <= wr_ptr[b] + FIFO_DEPTH_LOG2'(bank_push[b]);
          count[b]  <= count[b] + CW'(bank_push[b]) - CW'(bank_pop[b]);
        end
        if (cpu_accepts)
          accepted <= 1'b1;
        else if (quiet_done && current_character != '0 && !nxt_empty)
          sel <= ~sel;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regex_pc_scheduler.sv
`default_nettype none
// Bench for regex_pc_scheduler: directed vector table, scripted CPU sequences,
// and a randomized run against a queue-based reference model.
module tb_regex_pc_scheduler;

  localparam int D_DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        char_in_valid = 1'b0;
  logic [7:0]  char_in_data = 8'h00;
  logic        cpu_pc_ready = 1'b0;
  logic        ret_pc_valid = 1'b0;
  logic [7:0]  ret_pc = 8'h00;
  logic        ret_pc_is_directed_to_current = 1'b0;
  logic        cpu_running = 1'b0;
  logic        cpu_accepts = 1'b0;

  logic        char_in_ready, cpu_pc_valid, ret_pc_ready, busy, done, accepted;
  logic [7:0]  current_character, cpu_pc;
  logic [15:0] char_count;

  logic        s_char_in_ready, s_cpu_pc_valid, s_ret_pc_ready, s_busy, s_done, s_accepted;
  logic [7:0]  s_current_character, s_cpu_pc;
  logic [15:0] s_char_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regex_pc_scheduler u_dut (
    .clk(clk), .reset(reset), .start(start),
    .char_in_valid(char_in_valid), .char_in_data(char_in_data), .char_in_ready(char_in_ready),
    .current_character(current_character),
    .cpu_pc_valid(cpu_pc_valid), .cpu_pc(cpu_pc), .cpu_pc_ready(cpu_pc_ready),
    .ret_pc_valid(ret_pc_valid), .ret_pc(ret_pc),
    .ret_pc_is_directed_to_current(ret_pc_is_directed_to_current), .ret_pc_ready(ret_pc_ready),
    .cpu_running(cpu_running), .cpu_accepts(cpu_accepts),
    .busy(busy), .done(done), .accepted(accepted), .char_count(char_count)
  );

  regex_pc_scheduler #(.FIFO_DEPTH_LOG2(1)) u_small (
    .clk(clk), .reset(reset), .start(start),
    .char_in_valid(char_in_valid), .char_in_data(char_in_data), .char_in_ready(s_char_in_ready),
    .current_character(s_current_character),
    .cpu_pc_valid(s_cpu_pc_valid), .cpu_pc(s_cpu_pc), .cpu_pc_ready(cpu_pc_ready),
    .ret_pc_valid(ret_pc_valid), .ret_pc(ret_pc),
    .ret_pc_is_directed_to_current(ret_pc_is_directed_to_current), .ret_pc_ready(s_ret_pc_ready),
    .cpu_running(cpu_running), .cpu_accepts(cpu_accepts),
    .busy(s_busy), .done(s_done), .accepted(s_accepted), .char_count(s_char_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; char_in_valid = 1'b0; char_in_data = 8'h00; cpu_pc_ready = 1'b0;
    ret_pc_valid = 1'b0; ret_pc = 8'h00; ret_pc_is_directed_to_current = 1'b0;
    cpu_running = 1'b0; cpu_accepts = 1'b0;
  endtask

  // Layout: busy done accepted char_in_ready pc_valid ret_ready char[8] count[16] pc[8]
  function automatic logic [37:0] dut_vec();
    return {busy, done, accepted, char_in_ready, cpu_pc_valid, ret_pc_ready,
            current_character, char_count, cpu_pc_valid ? cpu_pc : 8'h00};
  endfunction

  // Reference model: CUR/NXT as plain queues, swapped wholesale on a character advance.
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DONE = 3;
  int          ph = P_IDLE;
  logic [7:0]  cur_q[$];
  logic [7:0]  nxt_q[$];
  logic        m_acc = 1'b0;
  logic [7:0]  m_char = 8'h00;
  logic [15:0] m_cnt = 16'h0;
  int          quiet = 0;

  function automatic logic [37:0] model_vec();
    logic pv, rr;
    pv = (ph == P_RUN) && (cur_q.size() != 0);
    if (ph != P_RUN)                        rr = 1'b0;
    else if (ret_pc_is_directed_to_current) rr = (cur_q.size() < D_DEPTH) || (pv && cpu_pc_ready);
    else                                    rr = (nxt_q.size() < D_DEPTH);
    return {(ph == P_LOAD) || (ph == P_RUN), ph == P_DONE, m_acc, ph == P_LOAD, pv, rr,
            m_char, m_cnt, pv ? cur_q[0] : 8'h00};
  endfunction

  task automatic model_step();
    logic [37:0] v;
    logic        quiet_now;
    if (reset) begin
      ph = P_IDLE; cur_q.delete(); nxt_q.delete();
      m_acc = 1'b0; m_char = 8'h00; m_cnt = 16'h0; quiet = 0;
      return;
    end
    case (ph)
      P_IDLE, P_DONE: if (start) begin
        cur_q.delete(); nxt_q.delete(); cur_q.push_back(8'h00);
        m_cnt = 16'h0; m_acc = 1'b0; ph = P_LOAD;
      end
      P_LOAD: if (char_in_valid) begin
        m_char = char_in_data;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
        quiet = 0; ph = P_RUN;
      end
      default: begin
        v = model_vec();
        quiet_now = (cur_q.size() == 0) && !cpu_running && !ret_pc_valid;
        if (v[33] && cpu_pc_ready) void'(cur_q.pop_front());
        if (ret_pc_valid && v[32]) begin
          if (ret_pc_is_directed_to_current) cur_q.push_back(ret_pc);
          else                               nxt_q.push_back(ret_pc);
        end
        quiet = quiet_now ? quiet + 1 : 0;
        if (cpu_accepts) begin
          m_acc = 1'b1; ph = P_DONE;
        end else if (quiet >= 2) begin
          if (m_char == 8'h00 || nxt_q.size() == 0) ph = P_DONE;
          else begin cur_q = nxt_q; nxt_q.delete(); ph = P_LOAD; end
        end
      end
    endcase
  endtask

  typedef struct packed {
    logic st, cv; logic [7:0] cd; logic pr, rv; logic [7:0] rpc; logic rd, run, acc;
    logic e_busy, e_done, e_acc, e_cir, e_pv; logic [7:0] e_pc; logic e_rr; logic [15:0] e_cnt;
  } vec_t;
  vec_t tbl [16];

  logic [7:0] chars [4];

  // Scripted CPU: each dispatched PC returns pc+1 to NXT next cycle; on NUL optionally accepts.
  task automatic run_chain(input int len, input bit acc_nul, input string nm,
                           input int exp_cnt, input bit exp_acc);
    int idx = 0, loads = 0;
    logic pend_v = 1'b0, pend_a = 1'b0;
    logic [7:0] pend_pc = 8'h00;
    logic [7:0] got[$];
    logic [15:0] final_cnt;
    @(negedge clk); idle_inputs(); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      char_in_valid = (idx < len);
      char_in_data  = (idx < len) ? chars[idx] : 8'h00;
      cpu_pc_ready  = 1'b1;
      ret_pc_valid  = pend_v; ret_pc = pend_pc; cpu_accepts = pend_a;
      cpu_running   = pend_v | pend_a;
      pend_v = 1'b0; pend_a = 1'b0;
      #1;
      if (char_in_ready && char_in_valid) begin idx++; loads++; end
      if (cpu_pc_valid) begin
        got.push_back(cpu_pc);
        if (current_character == 8'h00 && acc_nul) pend_a = 1'b1;
        else begin pend_v = 1'b1; pend_pc = cpu_pc + 8'h01; end
      end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_accepted"}, 64'(accepted), 64'(exp_acc));
    chk({nm, "_char_count"}, 64'(char_count), 64'(exp_cnt));
    chk({nm, "_loads"}, 64'(loads), 64'(len));
    chk({nm, "_dispatches"}, 64'(got.size()), 64'(len));
    for (int i = 0; i < len; i++)
      chk($sformatf("%s_pc%0d", nm, i), 64'((i < got.size()) ? got[i] : 8'hEE), 64'(i));
    final_cnt = char_count;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); char_in_valid = 1'b1; char_in_data = 8'h41; #1;
      chk({nm, "_no_consume"}, 64'({char_in_ready, char_count}), 64'({1'b0, final_cnt}));
    end
    idle_inputs();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got[$];
    logic       pend;

    //                st cv cd     pr rv rpc   rd run acc  busy done acc cir pv pc    rr cnt
    tbl[0]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,16'd0};
    tbl[1]  = '{1'b0,1'b1,8'h61,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,16'd0};
    tbl[2]  = '{1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,8'h00,1'b1,16'd1};
    tbl[3]  = '{1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,16'd1};
    tbl[4]  = '{1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,16'd1};
    tbl[5]  = '{1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,16'd1};
    tbl[6]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,8'h00,1'b0,16'd1};
    tbl[7]  = '{1'b0,1'b1,8'h78,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,16'd0};
    tbl[8]  = '{1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,8'h00,1'b1,16'd1};
    tbl[9]  = '{1'b0,1'b0,8'h00,1'b0,1'b1,8'h01,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,16'd1};
    tbl[10] = '{1'b0,1'b0,8'h00,1'b1,1'b1,8'h05,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,8'h01,1'b1,16'd1};
    tbl[11] = '{1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,8'h05,1'b1,16'd1};
    tbl[12] = '{1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,16'd1};
    tbl[13] = '{1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,16'd1};
    tbl[14] = '{1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,16'd1};
    tbl[15] = '{1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,16'd1};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_state", 64'(dut_vec()), 64'd0);

    // Immediate accept, then SPLIT fan-out ending on an empty NXT
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start = tbl[i].st; char_in_valid = tbl[i].cv; char_in_data = tbl[i].cd;
      cpu_pc_ready = tbl[i].pr; ret_pc_valid = tbl[i].rv; ret_pc = tbl[i].rpc;
      ret_pc_is_directed_to_current = tbl[i].rd; cpu_running = tbl[i].run; cpu_accepts = tbl[i].acc;
      #1;
      chk($sformatf("vec%0d", i),
          64'({busy, done, accepted, char_in_ready, cpu_pc_valid, ret_pc_ready, char_count}),
          64'({tbl[i].e_busy, tbl[i].e_done, tbl[i].e_acc, tbl[i].e_cir, tbl[i].e_pv, tbl[i].e_rr, tbl[i].e_cnt}));
      if (tbl[i].e_pv) chk($sformatf("vec%0d_pc", i), 64'(cpu_pc), 64'(tbl[i].e_pc));
    end

    chars[0] = 8'h61; chars[1] = 8'h62; chars[2] = 8'h00; chars[3] = 8'h00;
    run_chain(3, 1'b1, "chain", 3, 1'b1);
    chars[0] = 8'h61; chars[1] = 8'h00;
    run_chain(2, 1'b0, "term", 2, 1'b0);

    // Backpressure on the depth-2 instance
    @(negedge clk); idle_inputs(); reset = 1'b1;
    @(negedge clk); reset = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0; char_in_valid = 1'b1; char_in_data = 8'h61;
    @(negedge clk); char_in_valid = 1'b0; cpu_pc_ready = 1'b1; cpu_running = 1'b1;
    #1 chk("bp_first_dispatch", 64'({s_cpu_pc_valid, s_cpu_pc}), 64'({1'b1, 8'h00}));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cpu_pc_ready = 1'b0; ret_pc_valid = 1'b1; ret_pc_is_directed_to_current = 1'b1;
      ret_pc = (k < 2) ? 8'(10 + k) : 8'd12;
      #1 chk($sformatf("bp_ready%0d", k), 64'(s_ret_pc_ready), 64'(k < 2));
    end
    pend = 1'b1;
    got.delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cpu_pc_ready = 1'b1; ret_pc_valid = pend; ret_pc = 8'd12;
      #1;
      if (c == 0) chk("bp_full_pop_push_ready", 64'(s_ret_pc_ready), 64'd1);
      if (s_cpu_pc_valid) got.push_back(s_cpu_pc);
      if (ret_pc_valid && s_ret_pc_ready) pend = 1'b0;
    end
    chk("bp_dispatch_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("bp_order%0d", i), 64'((i < got.size()) ? got[i] : 8'hEE), 64'(10 + i));

    // Reset mid-match with queued PCs, then restart
    @(negedge clk); idle_inputs(); reset = 1'b1;
    @(negedge clk); reset = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0; char_in_valid = 1'b1; char_in_data = 8'h71;
    @(negedge clk); char_in_valid = 1'b0; cpu_running = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); ret_pc_valid = 1'b1; ret_pc_is_directed_to_current = 1'b1; ret_pc = 8'(20 + k);
    end
    @(negedge clk); ret_pc_valid = 1'b0;
    #1 chk("rst_pre_queue", 64'({busy, cpu_pc_valid, cpu_pc}), 64'({1'b1, 1'b1, 8'h00}));
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; idle_inputs();
    #1 chk("rst_outputs_zero", 64'(dut_vec()), 64'd0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; char_in_valid = 1'b1; char_in_data = 8'h7A;
    got.delete();
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk); char_in_valid = 1'b0; cpu_pc_ready = 1'b1;
      #1;
      if (cpu_pc_valid) got.push_back(cpu_pc);
    end
    chk("rst_restart_done", 64'({done, accepted}), 64'({1'b1, 1'b0}));
    chk("rst_restart_count", 64'(got.size()), 64'd1);
    chk("rst_restart_pc", 64'((got.size() > 0) ? got[0] : 8'hEE), 64'd0);

    // Randomized run against the reference model
    @(negedge clk); idle_inputs(); reset = 1'b1;
    #1 model_step();
    for (int i = 0; i < 4000; i++) begin
      bit heavy;
      heavy = (i >= 2000);
      @(negedge clk);
      reset         = ($urandom_range(0, 299) == 0);
      start         = ($urandom_range(0, 7) == 0);
      char_in_valid = 1'($urandom_range(0, 1));
      char_in_data  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cpu_pc_ready  = heavy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      ret_pc_valid  = heavy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      ret_pc        = 8'($urandom);
      ret_pc_is_directed_to_current = 1'($urandom_range(0, 1));
      cpu_running   = ($urandom_range(0, 3) == 0);
      cpu_accepts   = ($urandom_range(0, 59) == 0);
      #1;
      chk($sformatf("random@%0d", i), 64'(dut_vec()), 64'(model_vec()));
      model_step();
    end

    @(negedge clk); idle_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
